first_one_scanner: RTL and testbench

- Sequential successor to the combinational first-one operator.
- Accepts a WIDTH-bit vector over a valid/ready handshake, then emits every set bit as a one-hot beat with its binary index, one bit per beat.
- Scan order is selectable: LSB-first or MSB-first.
- Intended for interrupt/request walkers and free-list scanners that must service every asserted bit, not only the first.

---
 rtl/first_one_scanner.sv | 137 +++++++++++++
 tb/tb_first_one_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/first_one_scanner.sv
// first_one_scanner: accepts a vector over valid/ready, then walks every set
// bit as a one-hot beat plus binary index, LSB-first or MSB-first.
// Optional: define FIRST_ONE_SCANNER_COUNT_EN to add output_count, the number
// of set bits still pending including the current beat.
module first_one_scanner #(
  parameter int unsigned WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int unsigned INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [WIDTH-1:0]       output_onehot,
  output logic [INDEX_WIDTH-1:0] output_index,
  output logic                   output_last,
  output logic                   output_valid,
`ifdef FIRST_ONE_SCANNER_COUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] output_count,
`endif
  input  logic                   output_ready
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SCAN = 1'b1;

  logic                   state;
  logic                   state_next;
  logic [WIDTH-1:0]       pending;
  logic [WIDTH-1:0]       first_onehot;
  logic [INDEX_WIDTH-1:0] first_index;
  logic [WIDTH-1:0]       remaining;
  logic                   found;
  logic                   scan;
  logic                   last;
  logic                   load;
  logic                   handshake;

  assign scan      = (state == STATE_SCAN);
  assign remaining = pending & ~first_onehot;
  assign last      = (remaining == '0);
  assign load      = (state == STATE_IDLE) && input_valid && (input_data != '0);
  assign handshake = scan && output_ready;

  // Pick the first set bit of pending in the configured scan order.
  always_comb begin
    first_onehot = '0;
    first_index  = '0;
    found        = 1'b0;
    if (MSB_FIRST) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (!found && pending[i]) begin
          found           = 1'b1;
          first_onehot[i] = 1'b1;
          first_index     = INDEX_WIDTH'(i);
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!found && pending[i]) begin
          found           = 1'b1;
          first_onehot[i] = 1'b1;
          first_index     = INDEX_WIDTH'(i);
        end
      end
    end
  end

  // Outputs decode from registered state/pending; zero outside SCAN.
  always_comb begin
    input_ready   = (state == STATE_IDLE);
    output_valid  = scan;
    output_onehot = scan ? first_onehot : '0;
    output_index  = scan ? first_index : '0;
    output_last   = scan && last;
  end

  // Next-state: an all-zero vector is consumed without leaving IDLE.
  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE: if (load) state_next = STATE_SCAN;
      STATE_SCAN: if (handshake && last) state_next = STATE_IDLE;
      default:    state_next = STATE_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pending bits: loaded on accept, current bit cleared on each beat handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else if (load) begin
      pending <= input_data;
    end else if (handshake) begin
      pending <= remaining;
    end
  end

`ifdef FIRST_ONE_SCANNER_COUNT_EN
  localparam int unsigned COUNT_WIDTH = $clog2(WIDTH + 1);

  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] popcount;

  // Population count of the incoming vector.
  always_comb begin
    popcount = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      popcount = popcount + COUNT_WIDTH'(input_data[i]);
    end
  end

  // Remaining-beat counter: popcount at accept, minus one per handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= popcount;
    end else if (handshake) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  assign output_count = scan ? count : '0;
`endif

endmodule

// File: tb/tb_first_one_scanner.sv
// Bench for first_one_scanner: LSB-first and MSB-first instances share the
// same stimulus and are checked against a set-bit list model.
module tb_first_one_scanner;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IW    = $clog2(WIDTH);
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clock;
  logic             resetn;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             output_ready;

  logic             lsb_ready, lsb_valid, lsb_last;
  logic [WIDTH-1:0] lsb_onehot;
  logic [IW-1:0]    lsb_index;
  logic             msb_ready, msb_valid, msb_last;
  logic [WIDTH-1:0] msb_onehot;
  logic [IW-1:0]    msb_index;
`ifdef FIRST_ONE_SCANNER_COUNT_EN
  logic [CW-1:0]    lsb_count, msb_count;
`endif

  int n_cmp;
  int n_bad;

  first_one_scanner #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clock         (clock),
    .resetn        (resetn),
    .input_data    (input_data),
    .input_valid   (input_valid),
    .input_ready   (lsb_ready),
    .output_onehot (lsb_onehot),
    .output_index  (lsb_index),
    .output_last   (lsb_last),
    .output_valid  (lsb_valid),
`ifdef FIRST_ONE_SCANNER_COUNT_EN
    .output_count  (lsb_count),
`endif
    .output_ready  (output_ready)
  );

  first_one_scanner #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clock         (clock),
    .resetn        (resetn),
    .input_data    (input_data),
    .input_valid   (input_valid),
    .input_ready   (msb_ready),
    .output_onehot (msb_onehot),
    .output_index  (msb_index),
    .output_last   (msb_last),
    .output_valid  (msb_valid),
`ifdef FIRST_ONE_SCANNER_COUNT_EN
    .output_count  (msb_count),
`endif
    .output_ready  (output_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both scanners idle: ready high, every output field zero.
  task automatic check_idle(input string tag);
    check({tag, "/lsb_ready"},  32'(lsb_ready),  32'd1);
    check({tag, "/lsb_valid"},  32'(lsb_valid),  32'd0);
    check({tag, "/lsb_onehot"}, 32'(lsb_onehot), 32'd0);
    check({tag, "/lsb_index"},  32'(lsb_index),  32'd0);
    check({tag, "/lsb_last"},   32'(lsb_last),   32'd0);
    check({tag, "/msb_ready"},  32'(msb_ready),  32'd1);
    check({tag, "/msb_valid"},  32'(msb_valid),  32'd0);
    check({tag, "/msb_onehot"}, 32'(msb_onehot), 32'd0);
    check({tag, "/msb_index"},  32'(msb_index),  32'd0);
    check({tag, "/msb_last"},   32'(msb_last),   32'd0);
`ifdef FIRST_ONE_SCANNER_COUNT_EN
    check({tag, "/lsb_count"},  32'(lsb_count),  32'd0);
    check({tag, "/msb_count"},  32'(msb_count),  32'd0);
`endif
  endtask

  task automatic check_beat(input string tag, input int li, input int mi,
                            input bit last, input int left);
    check({tag, "/lsb_valid"},  32'(lsb_valid),  32'd1);
    check({tag, "/lsb_ready"},  32'(lsb_ready),  32'd0);
    check({tag, "/lsb_onehot"}, 32'(lsb_onehot), 32'd1 << li);
    check({tag, "/lsb_index"},  32'(lsb_index),  32'(li));
    check({tag, "/lsb_last"},   32'(lsb_last),   32'(last));
    check({tag, "/msb_valid"},  32'(msb_valid),  32'd1);
    check({tag, "/msb_ready"},  32'(msb_ready),  32'd0);
    check({tag, "/msb_onehot"}, 32'(msb_onehot), 32'd1 << mi);
    check({tag, "/msb_index"},  32'(msb_index),  32'(mi));
    check({tag, "/msb_last"},   32'(msb_last),   32'(last));
`ifdef FIRST_ONE_SCANNER_COUNT_EN
    check({tag, "/lsb_count"},  32'(lsb_count),  32'(left));
    check({tag, "/msb_count"},  32'(msb_count),  32'(left));
`endif
  endtask

  // Offer one vector at a negedge, then walk and check every beat.
  // Beat stall_beat is held off for stall_n cycles; noise drives random
  // input_valid/input_data during SCAN, which the scanners must ignore.
  task automatic run_vector(input string tag, input logic [WIDTH-1:0] v,
                            input int stall_beat, input int stall_n, input bit noise);
    int q[$];
    int k;
    check_idle({tag, "/pre"});
    input_data  = v;
    input_valid = 1'b1;
    @(negedge clock);
    input_valid = 1'b0;
    input_data  = WIDTH'($urandom);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) q.push_back(i);
    end
    k = q.size();
    if (k == 0) begin
      check_idle({tag, "/zero"});
      @(negedge clock);
      check_idle({tag, "/zero2"});
      return;
    end
    for (int b = 0; b < k; b++) begin
      int stalls;
      stalls = (b == stall_beat) ? stall_n : 0;
      for (int s = 0; s <= stalls; s++) begin
        check_beat($sformatf("%s/b%0d", tag, b), q[b], q[k-1-b], b == k - 1, k - b);
        output_ready = (s == stalls);
        input_valid  = (noise && !(s == stalls && b == k - 1)) ? 1'($urandom) : 1'b0;
        input_data   = WIDTH'($urandom);
        @(negedge clock);
      end
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    check_idle({tag, "/post"});
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    resetn       = 1'b0;
    input_valid  = 1'($urandom);
    input_data   = WIDTH'($urandom);
    output_ready = 1'($urandom);

    // Reset held with random inputs.
    repeat (3) begin
      @(negedge clock);
      check_idle("reset");
      input_valid  = 1'($urandom);
      input_data   = WIDTH'($urandom);
      output_ready = 1'($urandom);
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    resetn       = 1'b1;
    @(negedge clock);
    check_idle("after_reset");

    // Directed: three-bit vector, backpressure, zero and full vectors.
    run_vector("a4",       8'b1010_0100, -1, 0, 1'b0);
    run_vector("a4_stall", 8'b1010_0100,  1, 3, 1'b0);
    run_vector("zero",     8'h00,        -1, 0, 1'b0);
    run_vector("full",     8'hFF,        -1, 0, 1'b0);
    run_vector("single",   8'h80,        -1, 0, 1'b1);

    // Reset mid-scan of an all-ones vector.
    input_data  = 8'hFF;
    input_valid = 1'b1;
    @(negedge clock);
    input_valid = 1'b0;
    check_beat("mid/b0", 0, 7, 1'b0, 8);
    @(negedge clock);
    check_beat("mid/b1", 1, 6, 1'b0, 7);
    resetn = 1'b0;
    #1;
    check_idle("mid/reset");
    @(negedge clock);
    check_idle("mid/held");
    resetn = 1'b1;
    @(negedge clock);
    run_vector("after_mid", 8'b0000_0010, -1, 0, 1'b0);

    // Random vectors with random stalls and upstream noise.
    for (int r = 0; r < 30; r++) begin
      run_vector($sformatf("rnd%0d", r), WIDTH'($urandom),
                 int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
